// File: rtl/multicycle_control_pkg.sv
// mips_pkg: shared definitions for the multicycle MIPS controller.
//   - opcode constants seen in the instruction register
//   - the 4-bit controller state enum (encodings visible on the debug port)
//   - alu_op, alu_src_b and pc_source encodings (alu_op is also used by
//     aluControlUnit)
//   - ctrl_t: the bundle of per-state datapath control signals
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: signals between the multicycle controller and the
// datapath / memory side.
//   instr_op, mem_ready        : into the controller
//   datapath enables and muxes : out of the controller
//   state, illegal_op, retired_count : status / debug out of the controller
//
// Memory handshake: mem_read / mem_write act as the request valid. Once raised
// they stay asserted and unchanged until the cycle in which mem_ready=1; that
// cycle completes the access. mem_ready has no meaning while no request is up.
interface multicycle_control_if #(
  parameter int WORD_SIZE = 32
);
  logic [5:0]           instr_op;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 pc_write_cond;
  logic                 ir_write;
  logic                 i_or_d;
  logic                 mem_read;
  logic                 mem_write;
  logic                 mem_to_reg;
  logic                 reg_dst;
  logic                 reg_write;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           alu_op;
  logic [1:0]           pc_source;
  logic [3:0]           state;
  logic                 illegal_op;
  logic [WORD_SIZE-1:0] retired_count;

  modport master (
    input  instr_op, mem_ready,
    output pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, illegal_op, retired_count
  );

  modport slave (
    output instr_op, mem_ready,
    input  pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, illegal_op, retired_count
  );
endinterface

// File: rtl/multicycle_control_output_decode.sv
// mc_output_decode: purely combinational Moore decode of the controller state
// into datapath control signals. mem_ready only matters in FETCH, where the
// IR load and PC increment happen in the cycle the fetch completes.
//   state     : current controller state
//   mem_ready : memory completes the current access this cycle
//   ctrl      : control bundle; all zero for unused encodings
module mc_output_decode
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE:   ctrl.alu_src_b = SRC_B_IMM_SH2;
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      S_I_WB:     ctrl.reg_write = 1'b1;
      default:    ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: sequencing controller for the multicycle MIPS datapath.
// Walks each instruction through FETCH/DECODE/execute/memory/write-back states,
// stalling FETCH, MEM_RD and MEM_WR until mem_ready.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : multicycle_control_if master side (opcode and mem_ready in;
//              datapath controls, debug state, illegal_op pulse and
//              retired-instruction counter out)
module multicycle_control
  import mips_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master bus
);

  state_t               state_q;
  state_t               state_d;
  logic [5:0]           op_q;
  logic                 illegal_q;
  logic                 illegal_d;
  logic                 retire;
  logic [WORD_SIZE-1:0] retired_q;
  ctrl_t                ctrl;
  ctrl_t                ctrl_out;

  mc_output_decode u_decode (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  // retire marks the final cycle of a completed instruction; the counter
  // steps on the edge that leaves that state.
  always_comb begin
    state_d   = S_FETCH;
    retire    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.instr_op)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_I_EXEC;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      // The IR may already hold the next word, so use the opcode captured
      // in DECODE rather than the live instr_op.
      S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR: begin
        state_d = bus.mem_ready ? S_FETCH : S_MEM_WR;
        retire  = bus.mem_ready;
      end
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (state_q == S_DECODE) op_q <= bus.instr_op;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  // Reset squashes every enable in the same cycle so an aborted instruction
  // cannot write memory, registers or the PC.
  assign ctrl_out = rst ? '0 : ctrl;

  assign bus.pc_write      = ctrl_out.pc_write;
  assign bus.pc_write_cond = ctrl_out.pc_write_cond;
  assign bus.ir_write      = ctrl_out.ir_write;
  assign bus.i_or_d        = ctrl_out.i_or_d;
  assign bus.mem_read      = ctrl_out.mem_read;
  assign bus.mem_write     = ctrl_out.mem_write;
  assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
  assign bus.reg_dst       = ctrl_out.reg_dst;
  assign bus.reg_write     = ctrl_out.reg_write;
  assign bus.alu_src_a     = ctrl_out.alu_src_a;
  assign bus.alu_src_b     = ctrl_out.alu_src_b;
  assign bus.alu_op        = ctrl_out.alu_op;
  assign bus.pc_source     = ctrl_out.pc_source;
  assign bus.state         = state_q;
  assign bus.illegal_op    = illegal_q & ~rst;
  assign bus.retired_count = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Each instruction is expanded from its opcode
// into the list of states it must visit (plus memory wait cycles); every cycle
// is queued with its inputs and expected state, counter and illegal flag. A
// compare process checks all outputs on each falling edge, with expected
// control values taken from a per-state table.
module tb_multicycle_control;

  localparam int W = 32;

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4,
                         MW = 4'd5, RE = 4'd6, RW = 4'd7, BR = 4'd8, JP = 4'd9,
                         IE = 4'd10, IW = 4'd11;

  typedef struct {
    logic         in_rst;
    logic         known;
    logic [3:0]   st;
    logic         rdy;
    logic [W-1:0] ret;
    logic         ill;
  } cyc_t;

  logic clk;
  logic rst;
  multicycle_control_if #(.WORD_SIZE(W)) bus ();

  multicycle_control #(.WORD_SIZE(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  cyc_t         exp_q[$];
  logic [W-1:0] m_ret;
  logic         ill_pending;
  int           n_checks;
  int           n_fails;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Expected controls per state, order:
  // pc_write pc_write_cond ir_write i_or_d mem_read mem_write mem_to_reg
  // reg_dst reg_write alu_src_a alu_src_b[1:0] alu_op[1:0] pc_source[1:0]
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic rdy);
    logic pw, pwc, irw, iod, mr, mw, m2r, rd, rw, sa;
    logic [1:0] sb, aop, ps;
    {pw, pwc, irw, iod, mr, mw, m2r, rd, rw, sa} = '0;
    sb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (st)
      F:   begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
      D:   sb = 2'b11;
      MA:  begin sa = 1; sb = 2'b10; end
      MR:  begin mr = 1; iod = 1; end
      MWB: begin rw = 1; m2r = 1; end
      MW:  begin mw = 1; iod = 1; end
      RE:  begin sa = 1; aop = 2'b10; end
      RW:  begin rw = 1; rd = 1; end
      BR:  begin sa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
      JP:  begin pw = 1; ps = 2'b10; end
      IE:  begin sa = 1; sb = 2'b10; end
      IW:  rw = 1;
      default: ;
    endcase
    return {pw, pwc, irw, iod, mr, mw, m2r, rd, rw, sa, sb, aop, ps};
  endfunction

  // scoreboard: one compare per falling edge while expectations are queued
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cyc_t e;
      logic [15:0] got_ctrl;
      e = exp_q.pop_front();
      got_ctrl = {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.i_or_d,
                  bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.reg_dst,
                  bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                  bus.pc_source};
      check("ctrl", W'(got_ctrl), e.in_rst ? '0 : W'(exp_ctrl(e.st, e.rdy)));
      check("illegal_op", W'(bus.illegal_op), e.in_rst ? '0 : W'(e.ill));
      if (e.known) begin
        check("state", W'(bus.state), W'(e.st));
        check("retired_count", bus.retired_count, e.ret);
      end
    end
  end

  // driver: one cycle in state st; instr_op is junk outside DECODE
  task automatic step(input logic [3:0] st, input logic rdy, input logic [5:0] op);
    cyc_t e;
    rst = 1'b0;
    bus.mem_ready = rdy;
    bus.instr_op = (st == D) ? op : 6'($urandom_range(0, 63));
    e.in_rst = 1'b0; e.known = 1'b1; e.st = st; e.rdy = rdy;
    e.ret = m_ret; e.ill = ill_pending;
    ill_pending = 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic rst_cycle(input logic known, input logic [3:0] st);
    cyc_t e;
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    e.in_rst = 1'b1; e.known = known; e.st = st; e.rdy = 1'b0;
    e.ret = m_ret; e.ill = 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    m_ret = '0;
    ill_pending = 1'b0;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Whole instruction: fw FETCH waits, mw memory waits; n = cycles taken.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, output int n);
    int start;
    start = exp_q.size();
    n = 0;
    for (int i = 0; i < fw; i++) begin step(F, 1'b0, op); n++; end
    step(F, 1'b1, op); step(D, rnd(), op); n += 2;
    case (op)
      6'h00: begin step(RE, rnd(), op); step(RW, rnd(), op); n += 2; end
      6'h08: begin step(IE, rnd(), op); step(IW, rnd(), op); n += 2; end
      6'h04: begin step(BR, rnd(), op); n++; end
      6'h02: begin step(JP, rnd(), op); n++; end
      6'h23: begin
        step(MA, rnd(), op);
        for (int i = 0; i < mw; i++) step(MR, 1'b0, op);
        step(MR, 1'b1, op); step(MWB, rnd(), op);
        n += mw + 3;
      end
      6'h2B: begin
        step(MA, rnd(), op);
        for (int i = 0; i < mw; i++) step(MW, 1'b0, op);
        step(MW, 1'b1, op);
        n += mw + 2;
      end
      default: ill_pending = 1'b1;
    endcase
    if (op inside {6'h00, 6'h08, 6'h04, 6'h02, 6'h23, 6'h2B}) m_ret = m_ret + 1'b1;
  endtask

  initial begin
    int n;
    int total;
    n_checks = 0; n_fails = 0;
    m_ret = '0; ill_pending = 1'b0;
    rst = 1'b1; bus.mem_ready = 1'b0; bus.instr_op = 6'h00;
    @(posedge clk); #1;
    rst_cycle(1'b0, F);
    rst_cycle(1'b0, F);
    check("reset_state", W'(bus.state), W'(0));
    check("reset_retired", bus.retired_count, W'(0));

    // R-type, zero wait: 0,1,6,7
    run_instr(6'h00, 0, 0, n);
    check("rtype_cycles", W'(n), W'(4));
    check("rtype_retired", bus.retired_count, W'(1));

    // lw with 3 wait cycles in MEM_RD: 0,1,2,3,3,3,3,4
    run_instr(6'h23, 0, 3, n);
    check("lw_wait_cycles", W'(n), W'(8));
    check("lw_retired", bus.retired_count, W'(2));

    // FETCH stalled two cycles before an R-type
    run_instr(6'h00, 2, 0, n);
    check("fetch_wait_cycles", W'(n), W'(6));

    // beq, j, sw back to back: 3+3+4 cycles
    run_instr(6'h04, 0, 0, n); total = n;
    run_instr(6'h02, 0, 0, n); total += n;
    run_instr(6'h2B, 0, 0, n); total += n;
    check("beq_j_sw_cycles", W'(total), W'(10));
    check("beq_j_sw_retired", bus.retired_count, W'(6));

    // illegal opcode: back in FETCH with a one-cycle pulse, nothing retired
    run_instr(6'h3F, 0, 0, n);
    check("illegal_pulse", W'(bus.illegal_op), W'(1));
    check("illegal_state", W'(bus.state), W'(0));
    check("illegal_retired", bus.retired_count, W'(6));
    run_instr(6'h08, 0, 0, n);
    check("addi_retired", bus.retired_count, W'(7));

    // sw with memory wait, then reset while stalled in MEM_WR
    step(F, 1'b1, 6'h2B); step(D, 1'b1, 6'h2B); step(MA, 1'b1, 6'h2B);
    step(MW, 1'b0, 6'h2B);
    rst_cycle(1'b1, MW);
    check("abort_state", W'(bus.state), W'(0));
    check("abort_retired", bus.retired_count, W'(0));
    run_instr(6'h00, 0, 0, n);

    // counter wrap from all-ones
    bus.mem_ready = 1'b0;
    force dut.retired_q = '1;
    m_ret = '1;
    step(F, 1'b0, 6'h00);
    release dut.retired_q;
    step(F, 1'b0, 6'h00);
    run_instr(6'h02, 0, 0, n);
    check("wrap_retired", bus.retired_count, W'(0));

    step(F, 1'b0, 6'h00);
    @(negedge clk); #1;
    check("queue_drained", W'(exp_q.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
